// File: rtl/alu_sequencer.sv
// Program sequencer for the Alu accumulator: writable instruction store, back-to-back
// issue with optional repeat passes, opcode screening, and tagged result capture.

package alu_sequencer_pkg;

  // Opcode encoding shared with the Alu instruction decoder.
  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_LDI = 4'h1,
    OP_ADD = 4'h2,
    OP_SUB = 4'h3,
    OP_NOT = 4'h4,
    OP_AND = 4'h5,
    OP_IOR = 4'h6,
    OP_XOR = 4'h7,
    OP_SHL = 4'h8,
    OP_SHR = 4'h9
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_ERROR
  } state_e;

  function automatic logic op_valid(input logic [3:0] op);
    return op inside {OP_NOP, OP_LDI, OP_ADD, OP_SUB, OP_NOT,
                      OP_AND, OP_IOR, OP_XOR, OP_SHL, OP_SHR};
  endfunction

endpackage

module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int PROG_DEPTH = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] prog_addr,
  input  logic [11:0]           prog_data,
  input  logic                  prog_wen,
  input  logic [ADDR_WIDTH-1:0] end_addr,
  input  logic [7:0]            loop_count,
  input  logic                  start,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [11:0]           alu_inst,
  output logic                  alu_inst_wen,
  input  logic [7:0]            alu_result,
  output logic [7:0]            result_out,
  output logic [ADDR_WIDTH-1:0] result_tag,
  output logic                  result_valid
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(PROG_DEPTH - 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [7:0]            pass_q, pass_d;
  logic [ADDR_WIDTH-1:0] end_q, end_d;
  logic [7:0]            loops_q, loops_d;
  logic                  suppress_q, suppress_d;
  logic [11:0]           inst_q, inst_d;
  logic                  wen_q, wen_d;
  logic [ADDR_WIDTH-1:0] tag_q, tag_d;
  logic                  done_q, done_d;

  logic                  cap_pend_q;
  logic [ADDR_WIDTH-1:0] cap_tag_q;
  logic [7:0]            res_q;
  logic [ADDR_WIDTH-1:0] res_tag_q;
  logic                  res_valid_q;

  logic [11:0]           mem [PROG_DEPTH];

  logic                  wr_ok;
  logic                  fetch_en;
  logic [ADDR_WIDTH-1:0] f_pc;
  logic [ADDR_WIDTH-1:0] f_end;
  logic [7:0]            f_loops;
  logic [7:0]            f_pass;
  logic [11:0]           f_word;
  logic                  f_valid;
  logic                  f_last;
  logic                  f_final;
  logic [ADDR_WIDTH-1:0] pc_inc;

  // ---------------------------------------------------------------------------
  // Instruction store
  // ---------------------------------------------------------------------------
  assign wr_ok = prog_wen && (state_q == S_IDLE || state_q == S_ERROR);

  // NOTE: the store is deliberately left out of reset so it maps onto plain
  // register/RAM cells and survives a controller reset.
  always_ff @(posedge clock) begin
    if (wr_ok) mem[prog_addr] <= prog_data;
  end

  // ---------------------------------------------------------------------------
  // Fetch context: the start edge is the first fetch, so in IDLE the run
  // parameters come straight from the ports instead of the latched copies.
  // ---------------------------------------------------------------------------
  assign fetch_en = (state_q == S_IDLE && start) || (state_q == S_RUN);
  assign f_pc     = (state_q == S_IDLE) ? '0         : pc_q;
  assign f_end    = (state_q == S_IDLE) ? end_addr   : end_q;
  assign f_loops  = (state_q == S_IDLE) ? loop_count : loops_q;
  assign f_pass   = (state_q == S_IDLE) ? 8'd0       : pass_q;

  // A write landing on the same edge as start must be what the run sees.
  assign f_word   = (wr_ok && prog_addr == f_pc) ? prog_data : mem[f_pc];
  assign f_valid  = op_valid(f_word[11:8]);
  assign f_last   = (f_pc == f_end);
  assign f_final  = f_last && (f_pass == f_loops);
  assign pc_inc   = (f_pc == LAST_ADDR) ? '0 : f_pc + 1'b1;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  // NOTE: every combinational target gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (!f_valid)     state_d = S_ERROR;
          else if (f_final) state_d = S_DRAIN;
          else              state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (!f_valid)     state_d = S_ERROR;
        else if (abort)   state_d = S_DRAIN;
        else if (f_final) state_d = S_DRAIN;
      end
      // Leave once the last issued word has been sampled by the Alu; its
      // result is captured on that same edge.
      S_DRAIN: if (!wen_q) state_d = S_IDLE;
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs and run bookkeeping
  // ---------------------------------------------------------------------------
  always_comb begin
    pc_d       = pc_q;
    pass_d     = pass_q;
    end_d      = end_q;
    loops_d    = loops_q;
    suppress_d = suppress_q;
    inst_d     = inst_q;
    wen_d      = 1'b0;
    tag_d      = tag_q;
    done_d     = 1'b0;

    if (fetch_en) begin
      if (!f_valid) begin
        inst_d = {OP_NOP, 8'h00};
      end else if (state_q == S_RUN && abort) begin
        suppress_d = 1'b1;
      end else begin
        inst_d     = f_word;
        wen_d      = 1'b1;
        tag_d      = f_pc;
        pc_d       = f_last ? '0 : pc_inc;
        pass_d     = f_last ? f_pass + 8'd1 : f_pass;
        end_d      = f_end;
        loops_d    = f_loops;
        suppress_d = 1'b0;
      end
    end

    if (state_q == S_DRAIN && !wen_q) done_d = !suppress_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q       <= '0;
      pass_q     <= '0;
      end_q      <= '0;
      loops_q    <= '0;
      suppress_q <= 1'b0;
      inst_q     <= '0;
      wen_q      <= 1'b0;
      tag_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      pass_q     <= pass_d;
      end_q      <= end_d;
      loops_q    <= loops_d;
      suppress_q <= suppress_d;
      inst_q     <= inst_d;
      wen_q      <= wen_d;
      tag_q      <= tag_d;
      done_q     <= done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Result capture: the Alu samples the issued word one edge after issue and
  // its accumulator is captured one edge after that.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cap_pend_q  <= 1'b0;
      cap_tag_q   <= '0;
      res_q       <= '0;
      res_tag_q   <= '0;
      res_valid_q <= 1'b0;
    end else begin
      cap_pend_q  <= wen_q;
      cap_tag_q   <= tag_q;
      res_valid_q <= cap_pend_q;
      if (cap_pend_q) begin
        res_q     <= alu_result;
        res_tag_q <= cap_tag_q;
      end
    end
  end

  assign busy         = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign error        = (state_q == S_ERROR);
  assign done         = done_q;
  assign alu_inst     = inst_q;
  assign alu_inst_wen = wen_q;
  assign result_out   = res_q;
  assign result_tag   = res_tag_q;
  assign result_valid = res_valid_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: a behavioural Alu accumulator closes the
// loop; table-driven program runs plus directed error/abort/reset sequences.

module tb_alu_sequencer;

  localparam int AW = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic [AW-1:0] prog_addr;
  logic [11:0]   prog_data;
  logic          prog_wen;
  logic [AW-1:0] end_addr;
  logic [7:0]    loop_count;
  logic          start;
  logic          abort;
  logic          busy, done, error;
  logic [11:0]   alu_inst;
  logic          alu_inst_wen;
  logic [7:0]    alu_result;
  logic [7:0]    result_out;
  logic [AW-1:0] result_tag;
  logic          result_valid;

  alu_sequencer #(.PROG_DEPTH(16), .ADDR_WIDTH(AW)) dut (
    .clock        (clock),
    .reset        (reset),
    .prog_addr    (prog_addr),
    .prog_data    (prog_data),
    .prog_wen     (prog_wen),
    .end_addr     (end_addr),
    .loop_count   (loop_count),
    .start        (start),
    .abort        (abort),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .alu_inst     (alu_inst),
    .alu_inst_wen (alu_inst_wen),
    .alu_result   (alu_result),
    .result_out   (result_out),
    .result_tag   (result_tag),
    .result_valid (result_valid)
  );

  always #5 clock = ~clock;

  // Behavioural Alu: accumulator updated at the edge where inst_wen is high.
  logic [7:0] acc;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) acc <= 8'h00;
    else if (alu_inst_wen) begin
      case (alu_inst[11:8])
        4'h1:    acc <= alu_inst[7:0];
        4'h2:    acc <= acc + alu_inst[7:0];
        4'h3:    acc <= acc - alu_inst[7:0];
        4'h4:    acc <= ~acc;
        4'h5:    acc <= acc & alu_inst[7:0];
        4'h6:    acc <= acc | alu_inst[7:0];
        4'h7:    acc <= acc ^ alu_inst[7:0];
        4'h8:    acc <= acc << alu_inst[2:0];
        4'h9:    acc <= acc >> alu_inst[2:0];
        default: acc <= acc;
      endcase
    end
  end
  assign alu_result = acc;

  // Monitor: monotonic counters, sampled on the falling edge.
  logic [7:0]    rq[$];
  logic [AW-1:0] tq[$];
  int n_done = 0, n_mis = 0, n_wen = 0, n_rise = 0, n_badop = 0;
  logic wen_prev = 1'b0;

  always @(negedge clock) begin
    if (result_valid) begin
      rq.push_back(result_out);
      tq.push_back(result_tag);
    end
    if (done) n_done++;
    if (done && !result_valid) n_mis++;
    if (alu_inst_wen) n_wen++;
    if (alu_inst_wen && !wen_prev) n_rise++;
    wen_prev = alu_inst_wen;
    if (alu_inst[11:8] > 4'd9) n_badop++;
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  int s_res, s_done, s_mis, s_wen, s_rise, s_badop;

  task automatic snap();
    s_res   = rq.size();
    s_done  = n_done;
    s_mis   = n_mis;
    s_wen   = n_wen;
    s_rise  = n_rise;
    s_badop = n_badop;
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [11:0] w);
    prog_addr = a;
    prog_data = w;
    prog_wen  = 1'b1;
    @(posedge clock); #1;
    prog_wen  = 1'b0;
  endtask

  task automatic kick(input logic [AW-1:0] e, input logic [7:0] l);
    snap();
    end_addr   = e;
    loop_count = l;
    start      = 1'b1;
    @(posedge clock); #1;
    start      = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int cyc;
    for (cyc = 0; cyc < 300; cyc++) begin
      @(negedge clock);
      if (!busy) break;
    end
    check({name, "_idle"}, {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clock);
    @(posedge clock); #1;
  endtask

  // Results since the last snapshot; element i of the packed tables sits in the low bits.
  task automatic check_results(input string name, input int nexp,
                               input logic [63:0] exp_res, input logic [31:0] exp_tag);
    logic [7:0]    r;
    logic [AW-1:0] t;
    check({name, "_nres"}, 32'(rq.size() - s_res), 32'(nexp));
    for (int i = 0; i < nexp; i++) begin
      r = (s_res + i < rq.size()) ? rq[s_res + i] : 8'hxx;
      t = (s_res + i < tq.size()) ? tq[s_res + i] : 4'hx;
      check($sformatf("%s_res%0d", name, i), {24'd0, r}, {24'd0, exp_res[i*8 +: 8]});
      check($sformatf("%s_tag%0d", name, i), {28'd0, t}, {28'd0, exp_tag[i*4 +: 4]});
    end
  endtask

  typedef struct {
    string         name;
    logic [47:0]   prog;     // up to four words, word 0 in the low bits
    int            len;
    logic [AW-1:0] end_a;
    logic [7:0]    loops;
    int            nres;
    logic [63:0]   exp_res;
    logic [31:0]   exp_tag;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{"basic", 48'h000_302_201_11A, 3, 4'd2, 8'd0, 3,
                64'h0000_0000_0019_1B1A, 32'h0000_0210};
    vecs[1] = '{"loop",  48'h000_000_801_105, 2, 4'd1, 8'd2, 6,
                64'h0000_0A05_0A05_0A05, 32'h0010_1010};
    vecs[2] = '{"logic", 48'h7FF_63C_400_1F0, 4, 4'd3, 8'd0, 4,
                64'h0000_0000_C03F_0FF0, 32'h0000_3210};
    vecs[3] = '{"shift", 48'h000_902_5F0_1C3, 4, 4'd3, 8'd0, 4,
                64'h0000_0000_3030_C0C3, 32'h0000_3210};
    vecs[4] = '{"single", 48'h000_000_000_1AA, 1, 4'd0, 8'd1, 2,
                64'h0000_0000_0000_AAAA, 32'h0000_0000};

    reset = 1'b0; prog_addr = '0; prog_data = '0; prog_wen = 1'b0;
    end_addr = '0; loop_count = '0; start = 1'b0; abort = 1'b0;

    // Reset values
    repeat (2) @(posedge clock);
    #1;
    check("rst_alu_inst", {20'd0, alu_inst}, 32'h0);
    check("rst_outs", {26'd0, alu_inst_wen, busy, done, error, result_valid, 1'b0}, 32'h0);
    check("rst_result", {20'd0, result_tag, result_out}, 32'h0);
    reset = 1'b1;
    @(posedge clock); #1;

    // Table-driven program runs
    for (int v = 0; v < 5; v++) begin
      for (int w = 0; w < vecs[v].len; w++) load(AW'(w), vecs[v].prog[w*12 +: 12]);
      kick(vecs[v].end_a, vecs[v].loops);
      wait_idle(vecs[v].name);
      check_results(vecs[v].name, vecs[v].nres, vecs[v].exp_res, vecs[v].exp_tag);
      check({vecs[v].name, "_done"}, 32'(n_done - s_done), 32'd1);
      check({vecs[v].name, "_done_align"}, 32'(n_mis - s_mis), 32'd0);
      check({vecs[v].name, "_wen_cycles"}, 32'(n_wen - s_wen),
            32'(vecs[v].len * (int'(vecs[v].loops) + 1)));
      check({vecs[v].name, "_wen_bursts"}, 32'(n_rise - s_rise), 32'd1);
    end

    // Invalid opcode: one result, sticky error, start ignored
    load(4'd0, 12'h11A); load(4'd1, 12'hF02); load(4'd2, 12'h203);
    kick(4'd2, 8'd0);
    wait_idle("inv");
    check_results("inv", 1, 64'h1A, 32'h0);
    check("inv_error", {31'd0, error}, 32'd1);
    check("inv_badop", 32'(n_badop - s_badop), 32'd0);
    check("inv_done", 32'(n_done - s_done), 32'd0);
    check("inv_wen", 32'(n_wen - s_wen), 32'd1);
    kick(4'd2, 8'd0);
    repeat (4) @(negedge clock);
    check("inv_restart_error", {31'd0, error}, 32'd1);
    check("inv_restart_busy", {31'd0, busy}, 32'd0);
    check("inv_restart_wen", 32'(n_wen - s_wen), 32'd0);
    check("inv_restart_res", 32'(rq.size() - s_res), 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    #1;
    check("inv_reset_error", {31'd0, error}, 32'd0);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    load(4'd0, 12'h1AA);
    kick(4'd0, 8'd0);
    wait_idle("inv_rerun");
    check_results("inv_rerun", 1, 64'hAA, 32'h0);
    check("inv_rerun_done", 32'(n_done - s_done), 32'd1);

    // Abort on the second RUN cycle, with a locked-out write during RUN
    load(4'd0, 12'h11A); load(4'd1, 12'h201); load(4'd2, 12'h302);
    kick(4'd2, 8'd0);
    prog_addr = 4'd1; prog_data = 12'h1FF; prog_wen = 1'b1;
    @(posedge clock); #1;
    prog_wen = 1'b0; abort = 1'b1;
    @(posedge clock); #1;
    abort = 1'b0;
    check("abort_wen_after", {31'd0, alu_inst_wen}, 32'd0);
    wait_idle("abort");
    check_results("abort", 2, 64'h1B1A, 32'h10);
    check("abort_done", 32'(n_done - s_done), 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_wen", 32'(n_wen - s_wen), 32'd2);
    kick(4'd2, 8'd0);
    wait_idle("lockout");
    check_results("lockout", 3, 64'h19_1B1A, 32'h210);

    // Mid-run reset on the second issue cycle
    kick(4'd2, 8'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    #1;
    check("mrst_alu_inst", {20'd0, alu_inst}, 32'h0);
    check("mrst_outs", {27'd0, alu_inst_wen, busy, done, error, result_valid}, 32'h0);
    check("mrst_result", {20'd0, result_tag, result_out}, 32'h0);
    @(posedge clock); #1;
    reset = 1'b1;
    repeat (6) @(negedge clock);
    check("mrst_no_result", 32'(rq.size() - s_res), 32'd0);
    check("mrst_busy", {31'd0, busy}, 32'd0);
    @(posedge clock); #1;

    // Write and start on the same edge
    snap();
    prog_addr = 4'd0; prog_data = 12'h177; prog_wen = 1'b1;
    end_addr = 4'd0; loop_count = 8'd0; start = 1'b1;
    @(posedge clock); #1;
    prog_wen = 1'b0; start = 1'b0;
    wait_idle("wrstart");
    check_results("wrstart", 1, 64'h77, 32'h0);
    check("wrstart_done", 32'(n_done - s_done), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
